// File: rtl/fifo_sched.sv
// Round-robin push arbiter and push/pop sequencer in front of a ring-buffer FIFO; also keeps a shadow occupancy count.
// Latency: 0 cycles, because grants and FIFO strobes are combinational from the current inputs and registers.
// Backpressure: fifoFull blocks every ack and fifoEmpty blocks popAck. On contention, push and pop alternate.
// Optional statistics: define FIFO_SCHED_STATS_EN to build the saturating stallCount counter.
module fifo_sched #(
    parameter int NREQ = 4,
    parameter int MSBD = 1,
    parameter int LAST = 3,
    parameter int CNTW = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*(MSBD+1)-1:0]   reqData,
    output logic [NREQ-1:0]            ack,
    input  logic                       popReq,
    output logic                       popAck,
    output logic                       fifoPush,
    output logic                       fifoPop,
    output logic [MSBD:0]              fifoDataIn,
    input  logic                       fifoFull,
    input  logic                       fifoEmpty,
    output logic [CNTW-1:0]            count,
    output logic [15:0]                stallCount
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = MSBD + 1;

    logic [PW-1:0] rrPtr;
    logic          favorPop;

    logic          pushWant;
    logic          popWant;
    logic          contested;
    logic          doPush;
    logic          doPop;
    logic [PW-1:0] winner;
    logic          found;
    logic [PW-1:0] nextPtr;

    // Round-robin scan: the first requester at or after rrPtr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    // Operation select: a contested cycle goes to whichever side favorPop names, so push and pop are never both high.
    always_comb begin
        pushWant  = (|req) & ~fifoFull;
        popWant   = popReq & ~fifoEmpty;
        contested = pushWant & popWant;
        doPush    = ~reset & pushWant & ~(contested & favorPop);
        doPop     = ~reset & popWant & ~(contested & ~favorPop);
        nextPtr   = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

    // FIFO strobes, grant and data steering; all are zero unless an operation is chosen, including during reset.
    always_comb begin
        ack        = '0;
        fifoDataIn = '0;
        if (doPush) begin
            ack[winner] = 1'b1;
            fifoDataIn  = reqData[winner*DW +: DW];
        end
        fifoPush = doPush;
        fifoPop  = doPop;
        popAck   = doPop;
    end

    // Arbitration state and shadow occupancy; every register holds on an idle cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr    <= '0;
            favorPop <= 1'b0;
            count    <= '0;
        end else begin
            if (contested) begin
                favorPop <= ~favorPop;
            end
            if (doPush) begin
                rrPtr <= nextPtr;
            end
            if (doPush && (count != CNTW'(LAST + 1))) begin
                count <= count + 1'b1;
            end else if (doPop && (count != '0)) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef FIFO_SCHED_STATS_EN
    logic [15:0] stallReg;
    logic        stallEvent;

    // A stall is a producer blocked by a full FIFO, or a contested cycle that went to the consumer.
    always_comb begin
        stallEvent = ((|req) & fifoFull) | (contested & favorPop);
    end

    // Saturating stall counter, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stallReg <= '0;
        end else if (stallEvent && (stallReg != 16'hFFFF)) begin
            stallReg <= stallReg + 16'd1;
        end
    end

    assign stallCount = stallReg;
`else
    assign stallCount = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_sched.sv
// Bench for fifo_sched: directed scenarios followed by randomized traffic, checked every cycle against a reference model.
// The FIFO is modelled as a queue whose full/empty flags feed back into the scheduler.
// Expected grants come from a plain "first requester at or after the pointer" rule.
module tb_fifo_sched;
    localparam int NREQ  = 4;
    localparam int MSBD  = 1;
    localparam int LAST  = 3;
    localparam int CNTW  = 3;
    localparam int DW    = MSBD + 1;
    localparam int DEPTH = LAST + 1;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   reqData;
    logic [NREQ-1:0]      ack;
    logic                 popReq;
    logic                 popAck;
    logic                 fifoPush;
    logic                 fifoPop;
    logic [MSBD:0]        fifoDataIn;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [CNTW-1:0]      count;
    logic [15:0]          stallCount;

    fifo_sched #(.NREQ(NREQ), .MSBD(MSBD), .LAST(LAST), .CNTW(CNTW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .reqData    (reqData),
        .ack        (ack),
        .popReq     (popReq),
        .popAck     (popAck),
        .fifoPush   (fifoPush),
        .fifoPop    (fifoPop),
        .fifoDataIn (fifoDataIn),
        .fifoFull   (fifoFull),
        .fifoEmpty  (fifoEmpty),
        .count      (count),
        .stallCount (stallCount)
    );

    always #5 clock = ~clock;

    int nchk  = 0;
    int nfail = 0;

    // Reference model state.
    int          m_ptr;
    bit          m_fav;
    int          m_cnt;
    int          m_stall;
    logic [DW-1:0] fq[$];

    // Decisions expected for the current cycle.
    bit            e_push;
    bit            e_pop;
    bit            e_contest;
    bit            e_stallev;
    int            e_w;
    logic [NREQ-1:0] e_ack;
    logic [DW-1:0]   e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compute the expected outcome from the current inputs and model state, then compare it with the DUT.
    task automatic settle();
        bit full;
        bit empty;
        bit pw;
        bit pp;
        int j;
        #4;
        full  = (fq.size() == DEPTH);
        empty = (fq.size() == 0);
        pw    = (req != '0) && !full;
        pp    = popReq && !empty;
        e_contest = !reset && pw && pp;
        e_push    = !reset && pw && (!pp || !m_fav);
        e_pop     = !reset && pp && (!pw || m_fav);
        e_stallev = !reset && (((req != '0) && full) || (e_contest && m_fav));
        e_w = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (m_ptr + k) % NREQ;
            if (req[j]) e_w = j;
        end
        e_ack  = e_push ? (NREQ'(1) << e_w) : '0;
        e_data = e_push ? reqData[e_w*DW +: DW] : '0;
        chk("ack", ack, e_ack);
        chk("popAck", popAck, e_pop);
        chk("fifoPush", fifoPush, e_push);
        chk("fifoPop", fifoPop, e_pop);
        chk("fifoDataIn", fifoDataIn, e_data);
        chk("exclusive", fifoPush & fifoPop, 1'b0);
        chk("count", count, m_cnt);
`ifdef FIFO_SCHED_STATS_EN
        chk("stallCount", stallCount, m_stall);
`else
        chk("stallCount", stallCount, 16'd0);
`endif
    endtask

    // Clock edge: update the model and the FIFO queue, and refresh the FIFO flags.
    task automatic advance();
        logic [DW-1:0] dropped;
        @(posedge clock);
        #1;
        if (reset) begin
            m_ptr = 0; m_fav = 0; m_cnt = 0; m_stall = 0;
            fq.delete();
        end else begin
            if (e_contest) m_fav = !m_fav;
            if (e_stallev && m_stall < 65535) m_stall++;
            if (e_push) begin
                m_ptr = (e_w + 1) % NREQ;
                m_cnt++;
                fq.push_back(e_data);
            end
            if (e_pop) begin
                m_cnt--;
                dropped = fq.pop_front();
            end
        end
        fifoFull  = (fq.size() == DEPTH);
        fifoEmpty = (fq.size() == 0);
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        m_ptr = 0; m_fav = 0; m_cnt = 0; m_stall = 0;
        reset = 1'b1; req = '0; reqData = '0; popReq = 1'b0;
        fifoFull = 1'b0; fifoEmpty = 1'b1;

        // Reset: all outputs quiet.
        cyc();
        cyc();
        reset = 1'b0;

        // 1: four requesters are served in round-robin order, then the full FIFO blocks further grants.
        req = 4'b1111;
        reqData = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < NREQ; i++) begin
            settle();
            chk("rr_order", ack, 4'b0001 << i);
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("full_no_ack", ack, 4'b0000);
            chk("full_count", count, 3'd4);
            advance();
        end

        // 2: a full FIFO serves the pop, then contested cycles alternate between push and pop.
        req = 4'b0001; popReq = 1'b1;
        settle();
        chk("pop_from_full", popAck, 1'b1);
        advance();
        for (int i = 0; i < 8; i++) cyc();

        // 3: drain the FIFO, then a pop request on an empty FIFO waits.
        req = '0;
        for (int i = 0; i < 10 && fq.size() > 0; i++) cyc();
        chk("drained", fq.size(), 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("empty_no_pop", popAck, 1'b0);
            advance();
        end
        req = 4'b0100; reqData = 8'b00_10_00_00;
        settle();
        chk("push_N", fifoPush, 1'b1);
        advance();
        req = '0;
        settle();
        chk("pop_N1", popAck, 1'b1);
        advance();
        popReq = 1'b0;
        settle();
        chk("count_back", count, 3'd0);
        advance();

        // 4: the pointer wraps around to requester 0.
        req = 4'b0010; reqData = 8'b00_00_01_00;
        cyc();
        req = 4'b0011; reqData = 8'b00_00_11_10;
        settle();
        chk("wrap_ack0", ack, 4'b0001);
        advance();
        req = 4'b0010;
        settle();
        chk("wrap_ack1", ack, 4'b0010);
        advance();

        // 5: reset in the middle of traffic suppresses the grant and clears the state.
        req = 4'b0100; reset = 1'b1;
        settle();
        chk("rst_ack", ack, 4'b0000);
        chk("rst_push", fifoPush, 1'b0);
        advance();
        reset = 1'b0; req = 4'b1111;
        settle();
        chk("rst_count", count, 3'd0);
        chk("rst_ptr", ack, 4'b0001);
        advance();

        // 6: hold the FIFO full with a pending request for ten cycles.
        reset = 1'b1; req = '0;
        cyc();
        reset = 1'b0; req = 4'b1111;
        for (int i = 0; i < NREQ; i++) cyc();
        req = 4'b0001;
        for (int i = 0; i < 10; i++) cyc();
        settle();
`ifdef FIFO_SCHED_STATS_EN
        chk("stall10", stallCount, 16'd10);
`else
        chk("stall10", stallCount, 16'd0);
`endif
        advance();
        reset = 1'b1; req = '0;
        cyc();
        reset = 1'b0;

        // Randomized traffic: producers and the consumer hold their requests until acknowledged, with occasional withdrawals.
        for (int c = 0; c < 800; c++) begin
            settle();
            advance();
            reset = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && e_ack[i]) req[i] = 1'b0;
                else if (req[i] && ($urandom_range(0, 15) == 0)) req[i] = 1'b0;
                else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
                    req[i] = 1'b1;
                    reqData[i*DW +: DW] = DW'($urandom);
                end
            end
            if (popReq && e_pop) popReq = 1'b0;
            else if (!popReq && ($urandom_range(0, 1) == 0)) popReq = 1'b1;
            if (fq.size() == 0 && ($urandom_range(0, 49) == 0)) reset = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
